// File: rtl/fft_out_reorder.sv
// rtl/fft_out_reorder.sv - ping-pong reorder buffer turning FFT output into a natural-order stream
//
// Captures one N-point frame per bank (bit-reversed write address when BITREV=1)
// and replays full banks in natural order over a valid/ready interface.
//
// Ports:
//   iCLK, iRST          clock (rising edge), asynchronous active-high reset
//   iCLR                synchronous clear, same effect as reset, highest priority
//   iEN, iDATA_re/_im   input sample stream from the FFT
//   iREADY              downstream ready
//   oEN, oDATA_re/_im   output sample valid and data
//   oIDX, oSOF, oEOF    natural-order bin index, first / last bin markers
//   oOVF                sticky dropped-frame flag
//   oFRAME_CNT          frames fully delivered, wraps
module fft_out_reorder #(
  parameter int WL     = 16,
  parameter int LOG2N  = 4,
  parameter int BITREV = 1,
  parameter int FCW    = 8
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iCLR,
  input  logic             iEN,
  input  logic [WL-1:0]    iDATA_re,
  input  logic [WL-1:0]    iDATA_im,
  input  logic             iREADY,
  output logic             oEN,
  output logic [WL-1:0]    oDATA_re,
  output logic [WL-1:0]    oDATA_im,
  output logic [LOG2N-1:0] oIDX,
  output logic             oSOF,
  output logic             oEOF,
  output logic             oOVF,
  output logic [FCW-1:0]   oFRAME_CNT
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_FILL = 2'd1, W_DROP = 2'd2} wState_t;
  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rState_t;

  logic [2*WL-1:0] mem [2*N];

  wState_t          wState, wNext;
  rState_t          rState, rNext;
  logic [LOG2N-1:0] wCnt, wAddr, rCnt, loadIdx;
  logic             wBank, rBank, otherBank, loadBank;
  logic [1:0]       full;
  logic             memWe, setFull, ovfSet;
  logic             handshake, bankRelease, bankFree, load;

  assign oEN         = (rState == R_SEND);
  assign oIDX        = rCnt;
  assign oSOF        = oEN && (rCnt == '0);
  assign oEOF        = oEN && (rCnt == LAST_IDX);
  assign otherBank   = ~rBank;
  assign handshake   = oEN & iREADY;
  assign bankRelease = handshake & oEOF;
  // A bank being released on this edge counts as free for a frame starting on it.
  assign bankFree    = !full[wBank] || (bankRelease && (rBank == wBank));

  always_comb begin
    wAddr = wCnt;
    if (BITREV != 0) begin
      for (int i = 0; i < LOG2N; i++) wAddr[i] = wCnt[LOG2N-1-i];
    end
  end

  // ---------------- write side ----------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)      wState <= W_IDLE;
    else if (iCLR) wState <= W_IDLE;
    else           wState <= wNext;
  end

  always_comb begin
    wNext = wState;
    case (wState)
      W_IDLE:  if (iEN) wNext = bankFree ? W_FILL : W_DROP;
      W_FILL:  if (iEN && (wCnt == LAST_IDX)) wNext = W_IDLE;
      W_DROP:  if (iEN && (wCnt == LAST_IDX)) wNext = W_IDLE;
      default: wNext = W_IDLE;
    endcase
  end

  always_comb begin
    memWe   = 1'b0;
    setFull = 1'b0;
    ovfSet  = 1'b0;
    case (wState)
      W_IDLE: if (iEN) begin
        memWe  = bankFree;
        ovfSet = !bankFree;
      end
      W_FILL: if (iEN) begin
        memWe   = 1'b1;
        setFull = (wCnt == LAST_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wCnt  <= '0;
      wBank <= 1'b0;
      full  <= '0;
      oOVF  <= 1'b0;
    end else if (iCLR) begin
      wCnt  <= '0;
      wBank <= 1'b0;
      full  <= '0;
      oOVF  <= 1'b0;
    end else begin
      // wCnt wraps to 0 exactly at frame end, so W_IDLE always sees 0.
      if (iEN)         wCnt <= wCnt + 1'b1;
      if (setFull)     wBank <= ~wBank;
      if (ovfSet)      oOVF <= 1'b1;
      if (bankRelease) full[rBank] <= 1'b0;
      if (setFull)     full[wBank] <= 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (memWe && !iCLR && !iRST) mem[{wBank, wAddr}] <= {iDATA_re, iDATA_im};
  end

  // ---------------- read side ----------------
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)      rState <= R_IDLE;
    else if (iCLR) rState <= R_IDLE;
    else           rState <= rNext;
  end

  always_comb begin
    rNext = rState;
    case (rState)
      R_IDLE:  if (full[rBank]) rNext = R_SEND;
      R_SEND:  if (bankRelease && !full[otherBank]) rNext = R_IDLE;
      default: rNext = R_IDLE;
    endcase
  end

  // The output register only advances when empty or on a handshake, which
  // keeps data and markers frozen under backpressure.
  always_comb begin
    load     = 1'b0;
    loadBank = rBank;
    loadIdx  = '0;
    case (rState)
      R_IDLE: load = full[rBank];
      R_SEND: if (handshake) begin
        if (!oEOF) begin
          load    = 1'b1;
          loadIdx = rCnt + 1'b1;
        end else if (full[otherBank]) begin
          load     = 1'b1;
          loadBank = otherBank;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rBank      <= 1'b0;
      rCnt       <= '0;
      oDATA_re   <= '0;
      oDATA_im   <= '0;
      oFRAME_CNT <= '0;
    end else if (iCLR) begin
      rBank      <= 1'b0;
      rCnt       <= '0;
      oDATA_re   <= '0;
      oDATA_im   <= '0;
      oFRAME_CNT <= '0;
    end else begin
      if (bankRelease) begin
        rBank      <= otherBank;
        rCnt       <= '0;
        oFRAME_CNT <= oFRAME_CNT + 1'b1;
      end
      if (load) begin
        {oDATA_re, oDATA_im} <= mem[{loadBank, loadIdx}];
        rCnt                 <= loadIdx;
      end
    end
  end

endmodule
